// File: rtl/arpas_seq.sv
// arpas_seq: sequencer for the arpaspast timing datapath.
// Captures three element delays, shifts them LSB-first into timer channels
// A, B, C over the regdat/regclk/regsla/regslb port, then holds pdorun for
// max(delay)+PULSE cycles and pulses done on the final run cycle.
// Optional feature macro: ARPAS_SEQ_REPEAT_EN adds a GAP state that re-fires
// the array without reloading while start stays high.
module arpas_seq #(
  parameter int unsigned DW      = 13,
  parameter int unsigned CLKDIV  = 4,
  parameter int unsigned PULSE   = 16,
  parameter int unsigned REP_GAP = 32
) (
  input  logic          sysclk,
  input  logic          rstall_n,
  input  logic          start,
  input  logic [DW-1:0] dly_a,
  input  logic [DW-1:0] dly_b,
  input  logic [DW-1:0] dly_c,
  output logic          busy,
  output logic          done,
  output logic          regdat,
  output logic          regclk,
  output logic          regsla,
  output logic          regslb,
  output logic          rstall,
  output logic          pdorun
);

  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned RW = DW + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
  localparam logic [RW-1:0] PULSE_W  = RW'(PULSE);

  // Reject configurations that would make the strobe, pulse or gap vanish
  if (CLKDIV < 1 || PULSE < 1 || REP_GAP < 1) begin : g_bad_cfg
    $error("arpas_seq: CLKDIV, PULSE and REP_GAP must all be at least 1");
  end

`ifdef ARPAS_SEQ_REPEAT_EN
  localparam int unsigned GW = $clog2(REP_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(REP_GAP);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} state_t;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

  state_t                 state;
  logic [2:0][DW-1:0]     shadow;   // [0]=A, [1]=B, [2]=C
  logic [1:0]             ch;
  logic [BW-1:0]          bitn;
  logic [CW-1:0]          div;
  logic [RW-1:0]          run_len;  // max delay + PULSE, cannot wrap in RW bits
  logic [RW-1:0]          run_cnt;  // 1-based index of the current run cycle

  // Unsigned maximum of the three captured delays
  function automatic logic [DW-1:0] max3(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    logic [DW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Sequencer: state, counters and all registered outputs
  always_ff @(posedge sysclk or negedge rstall_n) begin
    if (!rstall_n) begin
      state   <= S_IDLE;
      shadow  <= '0;
      ch      <= '0;
      bitn    <= '0;
      div     <= '0;
      run_len <= '0;
      run_cnt <= '0;
`ifdef ARPAS_SEQ_REPEAT_EN
      gap_cnt <= '0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      regdat  <= 1'b0;
      regclk  <= 1'b0;
      regsla  <= 1'b1;
      regslb  <= 1'b1;
      rstall  <= 1'b1;
      pdorun  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow  <= {dly_c, dly_b, dly_a};
            run_len <= RW'(max3(dly_a, dly_b, dly_c)) + PULSE_W;
            ch      <= '0;
            bitn    <= '0;
            div     <= '0;
            busy    <= 1'b1;
            rstall  <= 1'b0;
            regdat  <= dly_a[0];
            regsla  <= 1'b0;
            regslb  <= 1'b0;
            regclk  <= 1'b0;
            state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (div != DIV_LAST) begin
            div <= div + CW'(1);
          end else begin
            div <= '0;
            if (!regclk) begin
              regclk <= 1'b1;
            end else begin
              // Data and select only move on the falling strobe edge
              regclk <= 1'b0;
              if (bitn != BIT_LAST) begin
                bitn   <= bitn + BW'(1);
                regdat <= shadow[ch][bitn + BW'(1)];
              end else if (ch != 2'd2) begin
                bitn   <= '0;
                ch     <= ch + 2'd1;
                regdat <= shadow[ch + 2'd1][0];
                regsla <= (ch == 2'd0);
                regslb <= (ch == 2'd1);
              end else begin
                bitn    <= '0;
                ch      <= '0;
                regdat  <= 1'b0;
                regsla  <= 1'b1;
                regslb  <= 1'b1;
                pdorun  <= 1'b1;
                run_cnt <= RW'(1);
                done    <= (run_len == RW'(1));
                state   <= S_RUN;
              end
            end
          end
        end

        S_RUN: begin
          if (run_cnt != run_len) begin
            run_cnt <= run_cnt + RW'(1);
            done    <= ((run_cnt + RW'(1)) == run_len);
          end else begin
            pdorun <= 1'b0;
            rstall <= 1'b1;
`ifdef ARPAS_SEQ_REPEAT_EN
            if (start) begin
              gap_cnt <= GW'(1);
              state   <= S_GAP;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
`else
            busy  <= 1'b0;
            state <= S_IDLE;
`endif
          end
        end

`ifdef ARPAS_SEQ_REPEAT_EN
        S_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GW'(1);
          end else if (start) begin
            rstall  <= 1'b0;
            pdorun  <= 1'b1;
            run_cnt <= RW'(1);
            done    <= (run_len == RW'(1));
            state   <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
`endif

        default: begin
          busy   <= 1'b0;
          rstall <= 1'b1;
          pdorun <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arpas_seq.sv
// tb_arpas_seq: waveform-level reference model plus directed and random pings.
module tb_arpas_seq;

  localparam int unsigned DW      = 13;
  localparam int unsigned CLKDIV  = 4;
  localparam int unsigned PULSE   = 16;
  localparam int unsigned REP_GAP = 32;
  localparam logic [7:0]  IDLE_V  = 8'b0000_1110;

  logic          sysclk   = 1'b0;
  logic          rstall_n = 1'b0;
  logic          start    = 1'b0;
  logic [DW-1:0] dly_a    = '0;
  logic [DW-1:0] dly_b    = '0;
  logic [DW-1:0] dly_c    = '0;
  logic busy, done, regdat, regclk, regsla, regslb, rstall, pdorun;

  arpas_seq #(.DW(DW), .CLKDIV(CLKDIV), .PULSE(PULSE), .REP_GAP(REP_GAP)) dut (
    .sysclk(sysclk), .rstall_n(rstall_n), .start(start),
    .dly_a(dly_a), .dly_b(dly_b), .dly_c(dly_c),
    .busy(busy), .done(done), .regdat(regdat), .regclk(regclk),
    .regsla(regsla), .regslb(regslb), .rstall(rstall), .pdorun(pdorun)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected output waveform: {busy,done,regdat,regclk,regsla,regslb,rstall,pdorun}
  logic [7:0] q[$];
  logic [7:0] exp_v = IDLE_V;
  int         kind  = 0;     // 1: queue ends with a run, 2: ends with a gap
  int         run_len_m = 0;

  // Monitor state
  logic       p_clk = 1'b0, p_pd = 1'b0, p_busy = 1'b0;
  logic [1:0] p_sel = 2'b11;
  logic [2:0] cap[$];
  int hi_cnt = 0, n_rise = 0, n_bad_high = 0, n_selv = 0;
  int pd_cnt = 0, pd_last = 0, n_done = 0, done_pd = 0, done_cyc = 0, fall_delta = 0;
  int idle_cnt = 0, n_idle1 = 0, g_cnt = 0, gap_last = 0, n_gaps = 0;

  function automatic logic [7:0] mk(input logic b, input logic d, input logic dat,
                                    input logic clk, input logic sa, input logic sb,
                                    input logic ra, input logic pd);
    return {b, d, dat, clk, sa, sb, ra, pd};
  endfunction

  function automatic logic [7:0] outs();
    return {busy, done, regdat, regclk, regsla, regslb, rstall, pdorun};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic push_load(input logic [DW-1:0] da, input logic [DW-1:0] db,
                           input logic [DW-1:0] dc);
    logic [DW-1:0] d;
    for (int c = 0; c < 3; c++) begin
      d = (c == 0) ? da : (c == 1) ? db : dc;
      for (int bt = 0; bt < int'(DW); bt++)
        for (int k = 0; k < 2 * int'(CLKDIV); k++)
          q.push_back(mk(1'b1, 1'b0, d[bt], (k >= int'(CLKDIV)), (c == 1), (c == 2),
                         1'b0, 1'b0));
    end
  endtask

  task automatic push_run(input int len);
    for (int i = 1; i <= len; i++)
      q.push_back(mk(1'b1, (i == len), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
  endtask

`ifdef ARPAS_SEQ_REPEAT_EN
  task automatic push_gap();
    for (int i = 0; i < int'(REP_GAP); i++)
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
  endtask
`endif

  // Advance the reference model across one rising edge
  task automatic model_step();
    int m;
    if (!rstall_n) begin
      q.delete();
      exp_v = IDLE_V;
    end else if (q.size() > 0) begin
      exp_v = q.pop_front();
    end else if (exp_v[7] == 1'b0) begin
      if (start) begin
        m = int'(dly_a);
        if (int'(dly_b) > m) m = int'(dly_b);
        if (int'(dly_c) > m) m = int'(dly_c);
        run_len_m = m + int'(PULSE);
        push_load(dly_a, dly_b, dly_c);
        push_run(run_len_m);
        kind  = 1;
        exp_v = q.pop_front();
      end
    end else begin
`ifdef ARPAS_SEQ_REPEAT_EN
      if (start && kind == 1) begin
        push_gap();
        kind  = 2;
        exp_v = q.pop_front();
      end else if (start && kind == 2) begin
        push_run(run_len_m);
        kind  = 1;
        exp_v = q.pop_front();
      end else begin
        exp_v = IDLE_V;
      end
`else
      exp_v = IDLE_V;
`endif
    end
  endtask

  // Derived waveform measurements used by the directed checks
  task automatic monitor();
    if (regclk && !p_clk) begin
      n_rise++;
      cap.push_back({regsla, regslb, regdat});
      hi_cnt = 1;
    end else if (regclk) begin
      hi_cnt++;
    end
    if (!regclk && p_clk && hi_cnt != int'(CLKDIV)) n_bad_high++;
    if (regclk && {regsla, regslb} != p_sel) n_selv++;
    if (pdorun) pd_cnt++;
    else if (p_pd) begin pd_last = pd_cnt; pd_cnt = 0; end
    if (done) begin n_done++; done_pd = pd_cnt; done_cyc = cyc; end
    if (p_busy && !busy) fall_delta = cyc - done_cyc;
    if (!busy) idle_cnt++;
    else if (!p_busy) begin
      if (idle_cnt == 1) n_idle1++;
      idle_cnt = 0;
    end
    if (busy && rstall) g_cnt++;
    else if (g_cnt > 0) begin gap_last = g_cnt; n_gaps++; g_cnt = 0; end
    p_clk = regclk; p_pd = pdorun; p_busy = busy; p_sel = {regsla, regslb};
  endtask

  // One clock: model update, per-cycle compare, measurements
  task automatic tick();
    @(posedge sysclk);
    cyc++;
    model_step();
    #1;
    check("outputs", 32'(outs()), 32'(exp_v));
    monitor();
  endtask

  task automatic ping(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c);
    dly_a = a; dly_b = b; dly_c = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20000 && n_done < target; i++) tick();
    check("wait_done", 32'(n_done >= target), 32'd1);
  endtask

  // Rebuild the three words from the strobed bits starting at cap[c0]
  task automatic decode_check(input int c0, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [DW-1:0] c);
    logic [DW-1:0] w[3];
    logic [2:0]    e;
    int            se;
    w[0] = '0; w[1] = '0; w[2] = '0; se = 0;
    for (int i = 0; i < 3 * int'(DW); i++) begin
      if (c0 + i < cap.size()) begin
        e = cap[c0 + i];
        if (e[2:1] != {(i / int'(DW) == 1), (i / int'(DW) == 2)}) se++;
        w[i / int'(DW)][i % int'(DW)] = e[0];
      end
    end
    check("stream_a", 32'(w[0]), 32'(a));
    check("stream_b", 32'(w[1]), 32'(b));
    check("stream_c", 32'(w[2]), 32'(c));
    check("stream_sel", 32'(se), 32'd0);
  endtask

  int r0, c0, d0, bh0, s0, i0, g0;
  logic [DW-1:0] ra, rb, rc;

  initial begin
    // Reset
    rstall_n = 1'b0;
    repeat (3) tick();
    check("reset_vals", 32'(outs()), 32'h0E);
    rstall_n = 1'b1;
    repeat (2) tick();

    // Serial load of 5 / 1 / 0x1ABC
    r0 = n_rise; c0 = cap.size(); bh0 = n_bad_high; s0 = n_selv; d0 = n_done;
    ping(13'd5, 13'd1, 13'h1ABC);
    check("busy_after_start", 32'({busy, rstall}), 32'b10);
    wait_done(d0 + 1);
    repeat (3) tick();
    check("rise_count", 32'(n_rise - r0), 32'd39);
    check("high_width", 32'(n_bad_high - bh0), 32'd0);
    check("sel_while_high", 32'(n_selv - s0), 32'd0);
    decode_check(c0, 13'd5, 13'd1, 13'h1ABC);
    check("run_len_1abc", 32'(pd_last), 32'd6860);
    check("busy_fall", 32'(fall_delta), 32'd1);

    // 3 / 7 / 2: run of 23 cycles
    d0 = n_done;
    ping(13'd3, 13'd7, 13'd2);
    check("model_len", 32'(q.size() + 1), 32'd335);
    wait_done(d0 + 1);
    repeat (3) tick();
    check("run_len_23", 32'(pd_last), 32'd23);
    check("done_on_last", 32'(done_pd), 32'd23);
    check("done_count", 32'(n_done - d0), 32'd1);
    check("busy_fall_23", 32'(fall_delta), 32'd1);

    // Delay extremes
    d0 = n_done;
    ping(13'd0, 13'd0, 13'd0);
    wait_done(d0 + 1);
    repeat (2) tick();
    check("run_len_zero", 32'(pd_last), 32'd16);
    d0 = n_done;
    ping(13'h1FFF, 13'h1FFF, 13'h1FFF);
    wait_done(d0 + 1);
    repeat (2) tick();
    check("run_len_max", 32'(pd_last), 32'd8207);

    // Async reset in the middle of channel B bit 6
    ra = DW'($urandom_range(0, 8191)); rb = DW'($urandom_range(0, 8191));
    rc = DW'($urandom_range(0, 200));
    ping(ra, rb, rc);
    repeat (156) tick();
    check("mid_b6_strobe", 32'({regclk, regsla, regslb}), 32'b110);
    #2 rstall_n = 1'b0;
    #1 check("reset_async", 32'(outs()), 32'h0E);
    tick();
    tick();
    rstall_n = 1'b1;
    tick();
    ra = DW'($urandom_range(0, 8191)); rb = DW'($urandom_range(0, 300));
    rc = DW'($urandom_range(0, 300));
    r0 = n_rise; c0 = cap.size(); d0 = n_done;
    ping(ra, rb, rc);
    wait_done(d0 + 1);
    repeat (2) tick();
    check("reload_rises", 32'(n_rise - r0), 32'd39);
    decode_check(c0, ra, rb, rc);

`ifndef ARPAS_SEQ_REPEAT_EN
    // start held: one IDLE cycle between pings, busy-time input changes ignored
    d0 = n_done; r0 = n_rise; i0 = n_idle1;
    start = 1'b1;
    for (int i = 0; i < 40000 && n_done < d0 + 2; i++) begin
      dly_a = DW'($urandom_range(0, 1000));
      dly_b = DW'($urandom_range(0, 1000));
      dly_c = DW'($urandom_range(0, 1000));
      tick();
    end
    start = 1'b0;
    check("held_done", 32'(n_done - d0), 32'd2);
    repeat (3) tick();
    check("idle_between", 32'(n_idle1 - i0), 32'd1);
    check("held_rises", 32'(n_rise - r0), 32'd78);
`else
    // Repeat mode: three pings from a single load
    d0 = n_done; r0 = n_rise; g0 = n_gaps;
    dly_a = 13'd3; dly_b = 13'd7; dly_c = 13'd2;
    start = 1'b1;
    for (int i = 0; i < 20000 && n_done < d0 + 2; i++) tick();
    for (int i = 0; i < 200 && !pdorun; i++) tick();
    start = 1'b0;
    wait_done(d0 + 3);
    repeat (3) tick();
    check("rep_done", 32'(n_done - d0), 32'd3);
    check("rep_rises", 32'(n_rise - r0), 32'd39);
    check("rep_gaps", 32'(n_gaps - g0), 32'd2);
    check("rep_gap_len", 32'(gap_last), 32'd32);
    check("rep_idle", 32'(busy), 32'd0);
`endif

    // Random start/delay activity, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      dly_a = DW'($urandom_range(0, 200));
      dly_b = DW'($urandom_range(0, 200));
      dly_c = DW'($urandom_range(0, 200));
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 20000 && busy; i++) tick();
    check("drain_idle", 32'(busy), 32'd0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arpas_seq.md
# arpas_seq

Sequencer for the ARPAS phased-array timing datapath (three `fltmr` channels behind `arpaspast`). It accepts three 13-bit per-element delays in one handshake. It then shifts them LSB-first into the channel registers over the `regdat`/`regclk`/`regsla`/`regslb` serial port, and fires the array by holding `pdorun` for the longest delay plus a pulse tail. It drives every control input of `arpaspast`, so no other logic touches those pins.

## Interface
- `DW`, 13: delay width, matches the timer counter width.
- `CLKDIV`, 4: `sysclk` cycles per `regclk` half-period; must be ≥1.
- `PULSE`, 16: `pdorun` cycles after the largest delay; 1..8191.
- `REP_GAP`, 32: `rstall` cycles between repeated pings; ≥1. Used only with `ARPAS_SEQ_REPEAT_EN`.

Ports:
- `sysclk`  in  1  system clock; all logic is rising-edge.
- `rstall_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request level, sampled only in IDLE.
- `dly_a`, `dly_b`, `dly_c`  in  DW  element delays in `sysclk` cycles; captured when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of each RUN.
- `regdat`  out  1  serial data to the timer.
- `regclk`  out  1  serial strobe to the timer.
- `regsla`, `regslb`  out  1  channel select.
- `rstall`  out  1  active-high clear to the timer counters and slot counters.
- `pdorun`  out  1  timer run enable.

## Operation
- Reset values: `busy=0`, `done=0`, `regdat=0`, `regclk=0`, `regsla=1`, `regslb=1`, `rstall=1`, `pdorun=0`.
- `sla/slb=1/1` selects no channel. Channel A=0/0, B=1/0, C=0/1. Select changes only while `regclk=0`.
- States are IDLE → LOAD → RUN → IDLE.
- IDLE:
  - `rstall=1`; all other outputs are at reset values.
  - `start=1` latches `dly_a/b/c` into shadow registers and computes `max` (DW bits, unsigned).
  - Next state is LOAD, with channel index 0 and bit index 0.
- LOAD:
  - `rstall=0`; channels are visited in order A, B, C, each bit 0 (LSB) to DW−1.
  - Per bit: `regdat` = shadow bit, select = channel.
  - For CLKDIV cycles `regclk=0` (setup), then for CLKDIV cycles `regclk=1`.
  - After the last bit of C: `regsla=regslb=1`, `regdat=0`, next state RUN.
- RUN:
  - `rstall=0`, `pdorun=1` for exactly `max+PULSE` cycles.
  - The run counter is DW+1 bits wide and compares against the zero-extended sum.
  - On the final cycle, next state is IDLE (without the macro) and `done=1` for one cycle.
- `start` held high across `done` begins a new LOAD after exactly one IDLE cycle. That IDLE cycle has `rstall=1`.
- Delay edge values:
  - All delays 0: RUN lasts exactly PULSE cycles.
  - All delays 8191: RUN lasts 8191+PULSE cycles with no wrap.
- Input changes on `start` or `dly_*` while `busy` are ignored.
- An async reset mid-LOAD or mid-RUN forces reset values immediately, including `regclk=0` with no partial strobe. It restarts in IDLE, and the timer is cleared because `rstall=1`.

## Timing
- `start` sampled high at edge N: `busy=1` and `rstall=0` from N+1.
- First `regclk` rise is at N+1+CLKDIV.
- LOAD lasts `3·DW·2·CLKDIV` cycles (312 cycles at defaults).
- `pdorun` rises on the cycle after the last `regclk` fall and lasts `max+PULSE` cycles.
- `done` coincides with the last `pdorun` cycle; `busy` falls on the following cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `ARPAS_SEQ_REPEAT_EN` defined:
  - After RUN, the block enters GAP if `start=1`.
  - GAP drives `rstall=1` and `pdorun=0` for REP_GAP cycles, then re-enters RUN without reloading. The channel data registers keep their values.
  - If `start=0` at the end of RUN or GAP, the block goes to IDLE.
  - `done` pulses at the end of every RUN.
- Undefined: no GAP state is compiled; RUN always goes to IDLE, and each ping requires a full reload.

## Test plan
- Reset, then `start` with `dly_a=5`, `dly_b=1`, `dly_c=0x1ABC`, CLKDIV=4:
  - exactly 39 `regclk` rises, each 4 cycles high;
  - decoded serial stream equals the delays LSB-first in order A, B, C;
  - the select never changes while `regclk=1`.
- Delays 3/7/2 with PULSE=16: `pdorun` high exactly 23 cycles; `done` is a single pulse on the 23rd; `busy` falls one cycle later.
- All delays 0, then all delays 8191: RUN lengths are 16 and 8207 cycles.
- `rstall_n` dropped midway through channel B's bit 6: next sample shows all outputs at reset values; a fresh `start` reloads from channel A bit 0.
- `start` held continuously (macro undefined): one IDLE cycle with `rstall=1` between `done` and the next LOAD; `dly_*` changes during the busy period do not affect the current sequence.
- With `ARPAS_SEQ_REPEAT_EN`, REP_GAP=32, `start` held for three pings then dropped:
  - three RUNs separated by 32-cycle `rstall` gaps;
  - only one LOAD;
  - three `done` pulses;
  - return to IDLE.
